// File: rtl/instr_mem_sync_if.sv
// Fetch, response, program-load and status signals of the instruction memory.
// master = core/loader side, slave = memory side.
interface instr_mem_sync_if #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_instr;
  logic [1:0]        resp_err;
  logic              load_we;
  logic [IDX_W-1:0]  load_addr;
  logic [31:0]       load_data;
  logic              busy;

  modport master (
    output fetch_valid, fetch_addr, resp_ready, load_we, load_addr, load_data,
    input  fetch_ready, resp_valid, resp_instr, resp_err, busy
  );

  modport slave (
    input  fetch_valid, fetch_addr, resp_ready, load_we, load_addr, load_data,
    output fetch_ready, resp_valid, resp_instr, resp_err, busy
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Loadable synchronous-read instruction memory: NOP-fill after reset, program
// load port, and a one-entry valid/ready fetch response register with error flags.
module instr_mem_sync #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  instr_mem_sync_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_cnt;
  logic             r_busy;
  logic             r_resp_valid;
  logic [31:0]      r_resp_instr;
  logic [1:0]       r_resp_err;

  // NOTE: the storage array has no reset; the clear engine initialises it instead.
  logic [31:0] r_mem [DEPTH];

  logic             w_fetch_ready;
  logic             w_accept;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic [IDX_W-1:0] w_fetch_idx;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [31:0]      w_mem_data;

  // A load cycle blocks acceptance, so a read and a write never share an edge.
  assign w_fetch_ready  = (r_state == ST_RUN) & ~bus.load_we
                        & (~r_resp_valid | bus.resp_ready);
  assign w_accept       = bus.fetch_valid & w_fetch_ready;

  // DEPTH is a power of two, so "word index >= DEPTH" means any upper bit set.
  assign w_misaligned   = |bus.fetch_addr[1:0];
  assign w_out_of_range = |bus.fetch_addr[ADDR_W-1:IDX_W+2];
  assign w_fetch_idx    = bus.fetch_addr[IDX_W+1:2];

  // Single write port shared by the clear engine and the program loader.
  assign w_mem_we   = ~reset & ((r_state == ST_CLEAR) | bus.load_we);
  assign w_mem_idx  = (r_state == ST_CLEAR) ? r_clr_cnt : bus.load_addr;
  assign w_mem_data = (r_state == ST_CLEAR) ? NOP_WORD  : bus.load_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + IDX_W'(1);
          if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  // Response register: reload on accept (even while being consumed), else drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_instr <= NOP_WORD;
      r_resp_err   <= 2'b00;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_err   <= {w_out_of_range, w_misaligned};
      if (w_misaligned | w_out_of_range) begin
        r_resp_instr <= NOP_WORD;
      end else begin
        r_resp_instr <= r_mem[w_fetch_idx];
      end
    end else if (r_resp_valid & bus.resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_instr  = r_resp_instr;
  assign bus.resp_err    = r_resp_err;
  assign bus.busy        = r_busy;

endmodule
